// File: rtl/reg_file_pkg.sv
// Shared types for the register file: clear-engine state encoding.
// Latency: n/a (types only).
// Backpressure: n/a.
package reg_file_pkg;

    localparam int STATE_BITS = 2;

    typedef enum logic [STATE_BITS-1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/reg_file_if.sv
// Bus bundle for the register file: write port, two read ports, clear control.
// Latency: n/a (wiring only); reads return one cycle after the address.
// Backpressure: none; writes issued while clr_busy is high are dropped.
// Ports: master drives we/waddr/wdata/raddr_a/raddr_b/clr_req, slave drives rdata_a/rdata_b/clr_busy/clr_done.
interface reg_file_if #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 3
);
    logic                 we;
    logic [ADDR_BITS-1:0] waddr;
    logic [WIDTH-1:0]     wdata;
    logic [ADDR_BITS-1:0] raddr_a;
    logic [ADDR_BITS-1:0] raddr_b;
    logic [WIDTH-1:0]     rdata_a;
    logic [WIDTH-1:0]     rdata_b;
    logic                 clr_req;
    logic                 clr_busy;
    logic                 clr_done;

    modport master (
        output we, waddr, wdata, raddr_a, raddr_b, clr_req,
        input  rdata_a, rdata_b, clr_busy, clr_done
    );

    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b, clr_req,
        output rdata_a, rdata_b, clr_busy, clr_done
    );
endinterface

// File: rtl/reg_file_rdmux.sv
// DEPTH-to-1 binary-tree read mux, WIDTH bits per entry.
// Latency: combinational.
// Backpressure: none.
// Ports: din (DEPTH entries), sel (entry index), dout (selected entry).
module reg_file_rdmux #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 3,
    parameter int DEPTH     = 1 << ADDR_BITS
) (
    input  logic [WIDTH-1:0]     din [DEPTH],
    input  logic [ADDR_BITS-1:0] sel,
    output logic [WIDTH-1:0]     dout
);
    // Heap-ordered tree: node 0 is the root, children of i are 2i+1 / 2i+2,
    // leaves occupy DEPTH-1 .. 2*DEPTH-2. The root resolves the sel MSB.
    logic [WIDTH-1:0] node [2*DEPTH-1];

    for (genvar k = 0; k < DEPTH; k++) begin : g_leaf
        assign node[DEPTH-1+k] = din[k];
    end

    for (genvar i = 0; i < DEPTH-1; i++) begin : g_node
        localparam int LVL = $clog2(i + 2) - 1;
        assign node[i] = sel[ADDR_BITS-1-LVL] ? node[2*i+2] : node[2*i+1];
    end

    assign dout = node[0];
endmodule

// File: rtl/reg_file.sv
// Register file: 2^ADDR_BITS x WIDTH, one write port, two registered read ports, sequenced clear.
// Latency: reads 1 cycle; clear takes DEPTH+1 cycles from acceptance back to idle.
// Backpressure: none; writes during a clear sweep are dropped, clr_req ignored unless idle.
// Ports: clk, rst (async active-low), bus (reg_file_if.slave).
// Optional: define REG_FILE_BYPASS_EN for same-edge write-to-read forwarding on each port.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    reg_file_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST = {ADDR_BITS{1'b1}};

    logic [WIDTH-1:0]     mem [DEPTH];
    state_t               state;
    logic [ADDR_BITS-1:0] cnt;
    logic                 busy_q;
    logic                 done_q;
    logic [WIDTH-1:0]     rdata_a_q;
    logic [WIDTH-1:0]     rdata_b_q;
    logic [WIDTH-1:0]     mux_a;
    logic [WIDTH-1:0]     mux_b;
    logic [WIDTH-1:0]     next_a;
    logic [WIDTH-1:0]     next_b;
    logic                 wr_acc;

    // Writes are only blocked while the sweep owns the array; DONE accepts them.
    assign wr_acc = bus.we && (state != ST_SWEEP);

    reg_file_rdmux #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .DEPTH(DEPTH)) u_mux_a (
        .din  (mem),
        .sel  (bus.raddr_a),
        .dout (mux_a)
    );

    reg_file_rdmux #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .DEPTH(DEPTH)) u_mux_b (
        .din  (mem),
        .sel  (bus.raddr_b),
        .dout (mux_b)
    );

`ifdef REG_FILE_BYPASS_EN
    assign next_a = (wr_acc && (bus.waddr == bus.raddr_a)) ? bus.wdata : mux_a;
    assign next_b = (wr_acc && (bus.waddr == bus.raddr_b)) ? bus.wdata : mux_b;
`else
    assign next_a = mux_a;
    assign next_b = mux_b;
`endif

    // Array: sweep zeroing has priority over (and excludes) the write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == ST_SWEEP) begin
            mem[cnt] <= '0;
        end else if (wr_acc) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            rdata_a_q <= next_a;
            rdata_b_q <= next_b;
        end
    end

    // Clear engine; busy/done are registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.clr_req) begin
                        state  <= ST_SWEEP;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    // Terminal compare: the counter stops at the last entry.
                    if (cnt == LAST) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + ADDR_BITS'(1);
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rdata_a  = rdata_a_q;
    assign bus.rdata_b  = rdata_b_q;
    assign bus.clr_busy = busy_q;
    assign bus.clr_done = done_q;
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file (WIDTH=8, ADDR_BITS=3): vector table, corner sequences, random traffic.
// Latency: expects 1-cycle reads and a DEPTH+1 cycle clear.
// Backpressure: checks that writes during a sweep are dropped.
module tb_reg_file;
    localparam int W = 8;
    localparam int AB = 3;
    localparam int DEPTH = 8;
`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_file_if #(.WIDTH(W), .ADDR_BITS(AB)) bus ();

    reg_file #(.WIDTH(W), .ADDR_BITS(AB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: array contents plus sweep position (-1 = not sweeping).
    logic [W-1:0] m_mem [DEPTH];
    int           m_pos;
    bit           m_done;
    logic [W-1:0] m_exp_a, m_exp_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_pos   = -1;
        m_done  = 1'b0;
        m_exp_a = '0;
        m_exp_b = '0;
    endtask

    task automatic model_step();
        bit sweeping, acc;
        if (!rst) begin
            model_reset();
            return;
        end
        sweeping = (m_pos >= 0);
        acc = bus.we && !sweeping;
        m_exp_a = (BYP && acc && bus.waddr == bus.raddr_a) ? bus.wdata : m_mem[bus.raddr_a];
        m_exp_b = (BYP && acc && bus.waddr == bus.raddr_b) ? bus.wdata : m_mem[bus.raddr_b];
        if (sweeping) begin
            m_mem[m_pos] = '0;
            m_pos++;
            if (m_pos == DEPTH) begin
                m_pos  = -1;
                m_done = 1'b1;
            end
        end else if (m_done) begin
            m_done = 1'b0;
            if (acc) m_mem[bus.waddr] = bus.wdata;
        end else begin
            if (acc) m_mem[bus.waddr] = bus.wdata;
            if (bus.clr_req) m_pos = 0;
        end
    endtask

    // One clock: model follows the edge, DUT outputs compared 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model_rdata_a", bus.rdata_a, m_exp_a);
        chk("model_rdata_b", bus.rdata_b, m_exp_b);
        chk("model_busy", bus.clr_busy, (m_pos >= 0));
        chk("model_done", bus.clr_done, m_done);
    endtask

    task automatic set_in(input logic we, input int wa, input logic [W-1:0] wd,
                          input int ra, input int rb, input logic cr);
        bus.we      = we;
        bus.waddr   = AB'(wa);
        bus.wdata   = wd;
        bus.raddr_a = AB'(ra);
        bus.raddr_b = AB'(rb);
        bus.clr_req = cr;
    endtask

    typedef struct {
        logic         we;
        int           wa;
        logic [W-1:0] wd;
        int           ra;
        int           rb;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int busy_cnt, done_cnt, done_at;
        int dn [$];
        logic b9, b10;

        vecs[0] = '{1'b1, 3, 8'hA5, 3, 4, BYP ? 8'hA5 : 8'h00, 8'h00};
        vecs[1] = '{1'b0, 0, 8'h00, 3, 3, 8'hA5, 8'hA5};
        vecs[2] = '{1'b0, 0, 8'h00, 4, 3, 8'h00, 8'hA5};
        vecs[3] = '{1'b1, 5, 8'h3C, 5, 3, BYP ? 8'h3C : 8'h00, 8'hA5};
        vecs[4] = '{1'b1, 5, 8'h77, 5, 5, BYP ? 8'h77 : 8'h3C, BYP ? 8'h77 : 8'h3C};
        vecs[5] = '{1'b0, 0, 8'h00, 5, 0, 8'h77, 8'h00};
        vecs[6] = '{1'b1, 0, 8'h01, 7, 0, 8'h00, BYP ? 8'h01 : 8'h00};
        vecs[7] = '{1'b0, 0, 8'h00, 0, 5, 8'h01, 8'h77};

        model_reset();
        set_in(1'b1, 2, 8'h99, 2, 2, 1'b1);
        #3;
        chk("reset_rdata_a", bus.rdata_a, 0);
        chk("reset_rdata_b", bus.rdata_b, 0);
        chk("reset_busy", bus.clr_busy, 0);
        chk("reset_done", bus.clr_done, 0);
        tick();
        tick();
        rst = 1'b1;
        set_in(1'b0, 0, 8'h00, 0, 0, 1'b0);
        tick();

        // Vector table.
        for (int i = 0; i < 8; i++) begin
            set_in(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb, 1'b0);
            tick();
            chk($sformatf("vec%0d_a", i), bus.rdata_a, vecs[i].ea);
            chk($sformatf("vec%0d_b", i), bus.rdata_b, vecs[i].eb);
        end

        // Clear sweep over a full array, with a write attempted mid-sweep.
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, i, 8'hFF, 0, 0, 1'b0);
            tick();
        end
        set_in(1'b0, 0, 8'h00, 0, 0, 1'b1);
        tick();
        chk("sweep_start_busy", bus.clr_busy, 1);
        busy_cnt = 1; done_cnt = 0; done_at = -1;
        for (int k = 1; k <= 10; k++) begin
            if (k == 3) set_in(1'b1, 2, 8'h11, 0, 0, 1'b0);
            else        set_in(1'b0, 0, 8'h00, 0, 0, 1'b0);
            tick();
            if (bus.clr_busy) busy_cnt++;
            if (bus.clr_done) begin done_cnt++; done_at = k; end
        end
        chk("sweep_busy_cycles", busy_cnt, 8);
        chk("sweep_done_count", done_cnt, 1);
        chk("sweep_done_at", done_at, 8);
        for (int i = 0; i < DEPTH / 2; i++) begin
            set_in(1'b0, 0, 8'h00, 2 * i, 2 * i + 1, 1'b0);
            tick();
            chk($sformatf("cleared_%0d", 2 * i), bus.rdata_a, 0);
            chk($sformatf("cleared_%0d", 2 * i + 1), bus.rdata_b, 0);
        end

        // Held clr_req across DONE: back-to-back sweeps.
        set_in(1'b0, 0, 8'h00, 0, 0, 1'b1);
        b9 = 1'b1; b10 = 1'b0;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (bus.clr_done) dn.push_back(e);
            if (e == 9)  b9 = bus.clr_busy;
            if (e == 10) b10 = bus.clr_busy;
        end
        set_in(1'b0, 0, 8'h00, 0, 0, 1'b0);
        chk("held_done_count", dn.size(), 2);
        if (dn.size() == 2) begin
            chk("held_done0_edge", dn[0], 8);
            chk("held_done1_edge", dn[1], 18);
        end
        chk("held_idle_gap_busy", b9, 0);
        chk("held_restart_busy", b10, 1);
        tick();
        tick();

        // Reset asserted in the middle of a sweep.
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, i, 8'h5A, 0, 0, 1'b0);
            tick();
        end
        set_in(1'b0, 0, 8'h00, 0, 0, 1'b1);
        tick();
        set_in(1'b0, 0, 8'h00, 5, 6, 1'b0);
        tick();
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("midrst_busy", bus.clr_busy, 0);
        chk("midrst_done", bus.clr_done, 0);
        chk("midrst_rdata_a", bus.rdata_a, 0);
        chk("midrst_rdata_b", bus.rdata_b, 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < DEPTH / 2; i++) begin
            set_in(1'b0, 0, 8'h00, 2 * i, 2 * i + 1, 1'b0);
            tick();
            chk("midrst_zero_a", bus.rdata_a, 0);
            chk("midrst_zero_b", bus.rdata_b, 0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, i, 8'h5A, 0, 0, 1'b0);
            tick();
        end
        set_in(1'b0, 0, 8'h00, 0, 1, 1'b1);
        tick();
        set_in(1'b0, 0, 8'h00, 0, 1, 1'b0);
        tick();
        tick();
        chk("restart_entry0", bus.rdata_a, 8'h00);
        chk("restart_entry1", bus.rdata_b, 8'h5A);
        for (int i = 0; i < 10; i++) tick();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), W'($urandom),
                   $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                   ($urandom_range(0, 19) == 0));
            tick();
        end

        // Reset in the middle of traffic.
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("trafrst_rdata_a", bus.rdata_a, 0);
        chk("trafrst_rdata_b", bus.rdata_b, 0);
        chk("trafrst_busy", bus.clr_busy, 0);
        chk("trafrst_done", bus.clr_done, 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < DEPTH / 2; i++) begin
            set_in(1'b0, 0, 8'h00, 2 * i, 2 * i + 1, 1'b0);
            tick();
            chk("trafrst_zero_a", bus.rdata_a, 0);
            chk("trafrst_zero_b", bus.rdata_b, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_file.md
# reg_file

Parametrised register file for the processor datapath: 2^ADDR_BITS entries of WIDTH bits, one write port, two registered read ports, and a sequenced clear engine that zeroes the array one entry per cycle on request. It replaces hand-instantiated enable/reset registers and fixed-width muxes in the execute stage, and feeds operand A/B of the ALU.

## Interface

- WIDTH, 8, bits per entry (≥1)
- ADDR_BITS, 3, address bits; DEPTH = 2^ADDR_BITS entries (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- we  in  1  write enable
- waddr  in  ADDR_BITS  write address
- wdata  in  WIDTH  write data
- raddr_a  in  ADDR_BITS  read address, port A
- raddr_b  in  ADDR_BITS  read address, port B
- rdata_a  out  WIDTH  registered read data, port A
- rdata_b  out  WIDTH  registered read data, port B
- clr_req  in  1  start clear sweep (level, sampled each cycle)
- clr_busy  out  1  sweep in progress
- clr_done  out  1  one-cycle pulse when sweep completes

## Operation

- Reset (rst=0, async): all entries = 0, rdata_a = rdata_b = 0, state = IDLE, sweep counter = 0, clr_busy = 0, clr_done = 0.
- Write: at rising edge with we=1 and state ≠ SWEEP, entry[waddr] ← wdata. we during SWEEP is dropped (no queueing).
- Read: each edge, rdata_x ← entry[raddr_x] (value before this edge's write, unless bypass enabled). Both ports independent; same address on both ports legal.
- Clear FSM (states IDLE, SWEEP, DONE):
  - IDLE: clr_req=1 → SWEEP, counter ← 0. Otherwise stay.
  - SWEEP: entry[counter] ← 0; counter increments; when counter == DEPTH-1 the last entry is zeroed and state → DONE. clr_req ignored.
  - DONE: clr_done=1 for this cycle; → IDLE unconditionally. clr_req here ignored; a held clr_req restarts sweep from IDLE on the following cycle.
- clr_busy = 1 exactly while state == SWEEP.
- Counter is ADDR_BITS wide; never wraps past DEPTH-1 (terminal compare, not overflow).
- Reads during SWEEP allowed; return current array contents (zeroed entries read 0).
- Reset asserted mid-sweep: immediate return to IDLE, all entries zeroed by reset.

## Timing

- Read latency: 1 cycle (address at edge N, data valid after edge N).
- Write visible on read ports 1 cycle after the write edge without bypass.
- Sweep: clr_req sampled at edge N → clr_busy high after N; DEPTH cycles of SWEEP; clr_done high for the cycle after the last zeroing edge; earliest re-accepted write at edge N+DEPTH+1 (the DONE cycle).
- Total clear cost: DEPTH+1 cycles from acceptance to IDLE.

## Configuration

- REG_FILE_BYPASS_EN defined: a read at edge N whose address equals waddr with an accepted write (we=1, not SWEEP) at edge N returns wdata (write-through forwarding), per port independently.
- Undefined: same-edge read returns the old entry contents; no forwarding logic built.

## Structure

- Shared package reg_file_pkg: state typedef (ST_IDLE, ST_SWEEP, ST_DONE) and its encoding width.
- One sub-module reg_file_rdmux: parametrised DEPTH-to-1, WIDTH-bit binary-tree read mux, instantiated once per read port; bypass compare lives in reg_file.

## Test plan

- Reset: hold rst=0 mid-traffic → all reads return 0x00, clr_busy=0, clr_done=0.
- Write/read: write 0xA5 to addr 3, then raddr_a=3, raddr_b=3 next cycle → both ports 0xA5 one cycle later; addr 4 still 0x00.
- Same-edge hazard: write 0x3C to addr 5 while raddr_a=5 → 0x3C with REG_FILE_BYPASS_EN, previous value without.
- Clear sweep (DEPTH=8): fill all entries with 0xFF, pulse clr_req → clr_busy high 8 cycles, clr_done single pulse on cycle 9, all entries read 0x00; write of 0x11 issued during SWEEP is lost.
- Held clr_req: keep clr_req=1 across DONE → second sweep starts the cycle after DONE; clr_done pulses once per sweep.
- Reset mid-sweep: assert rst at sweep cycle 3 → clr_busy drops immediately, no clr_done, array all zero, new clr_req restarts at entry 0.
